// File: rtl/exe_unit_pipe.sv
// Purpose : sign-magnitude (ZnMod) execution unit, 8 ops on a 3-bit opcode, iterative multiplier.
// Latency : 1 cycle from accept to o_valid for single-cycle ops, MBIT cycles for multiply (111).
// Backpr. : one op in flight; o_ready only in IDLE; result/status held in DONE until i_ready.
//
// Ports: i_clk/i_rst (sync, active-high); request i_valid/o_ready with i_argA, i_argB, i_oper;
//        response o_valid/i_ready with o_result and o_status {ERROR, ODD, ZERO, NEG};
//        o_op_cnt/o_err_cnt completed-op and error counters.
// Build option: define EXE_UNIT_STATS_EN to build the counters; otherwise they read 0.
module exe_unit_pipe #(
  parameter int MBIT = 8,
  parameter int NBIT = 3,
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [MBIT-1:0] i_argA,
  input  logic [MBIT-1:0] i_argB,
  input  logic [NBIT-1:0] i_oper,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [MBIT-1:0] o_result,
  output logic [3:0]      o_status,
  output logic [CNTW-1:0] o_op_cnt,
  output logic [CNTW-1:0] o_err_cnt
);

  localparam int M  = MBIT - 1;        // magnitude width
  localparam int CW = $clog2(MBIT);    // CALC step counter width

  localparam logic [NBIT-1:0] OP_INV = 3'b000;
  localparam logic [NBIT-1:0] OP_MAX = 3'b001;
  localparam logic [NBIT-1:0] OP_CLR = 3'b010;
  localparam logic [NBIT-1:0] OP_Z2U = 3'b011;
  localparam logic [NBIT-1:0] OP_SET = 3'b100;
  localparam logic [NBIT-1:0] OP_U2Z = 3'b101;
  localparam logic [NBIT-1:0] OP_ADD = 3'b110;
  localparam logic [NBIT-1:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic            err;
    logic [MBIT-1:0] res;
  } alu_out_t;

  // Status is derived from the value actually presented, so an error
  // (result forced to 0) always reads {1,0,1,0}.
  function automatic logic [3:0] status_of(input alu_out_t o);
    logic [MBIT-1:0] r;
    r = o.err ? '0 : o.res;
    return {o.err, ^r, (r == '0), r[MBIT-1]};
  endfunction

  state_t state, state_nxt;
  logic   accept;

  assign accept  = i_valid & o_ready;
  assign o_valid = (state == DONE);

  // ---------------------------------------------------------------
  // Single-cycle datapath, evaluated on the raw request inputs
  // ---------------------------------------------------------------
  logic                   sa, sb;
  logic [M-1:0]           ma, mb;
  logic signed [MBIT:0]   va, vb;
  logic [M:0]             mag_sum;
  logic [M-1:0]           mag_diff;
  logic                   a_ge_b;
  logic [31:0]            bit_idx;
  logic [MBIT-1:0]        bit_mask;
  logic [MBIT-1:0]        neg_a;
  logic [MBIT-1:0]        min_neg;
  alu_out_t               alu;

  assign sa       = i_argA[MBIT-1];
  assign sb       = i_argB[MBIT-1];
  assign ma       = i_argA[M-1:0];
  assign mb       = i_argB[M-1:0];
  // Signed values for the max compare; +0 and -0 both map to 0.
  assign va       = sa ? -$signed({2'b00, ma}) : $signed({2'b00, ma});
  assign vb       = sb ? -$signed({2'b00, mb}) : $signed({2'b00, mb});
  assign mag_sum  = {1'b0, ma} + {1'b0, mb};
  assign a_ge_b   = (ma >= mb);
  assign mag_diff = a_ge_b ? (ma - mb) : (mb - ma);
  assign bit_idx  = 32'(i_argB);
  assign bit_mask = MBIT'(1) << bit_idx;
  assign neg_a    = ~i_argA + 1'b1;
  assign min_neg  = {1'b1, {M{1'b0}}};

  always_comb begin
    alu = '0;
    case (i_oper)
      OP_INV: alu.res = {~sb, mb};
      OP_MAX: alu.res = (va >= vb) ? i_argA : i_argB;
      OP_CLR, OP_SET: begin
        // A negative index always exceeds MBIT, but both terms are kept explicit.
        alu.err = sb | (bit_idx >= 32'(MBIT));
        alu.res = (i_oper == OP_SET) ? (i_argA | bit_mask) : (i_argA & ~bit_mask);
      end
      OP_Z2U: begin
        if (i_argA == min_neg) alu.err = 1'b1;
        else                   alu.res = sa ? (~{1'b0, ma} + 1'b1) : i_argA;
      end
      OP_U2Z: begin
        if (i_argA == min_neg) alu.err = 1'b1;
        else if (sa)           alu.res = {1'b1, neg_a[M-1:0]};
        else                   alu.res = i_argA;
      end
      OP_ADD: begin
        if (sa == sb) begin
          alu.err = mag_sum[M];
          alu.res = {sa & (mag_sum[M-1:0] != '0), mag_sum[M-1:0]};
        end else begin
          // Sign follows the larger magnitude; a zero difference is +0.
          alu.res = {(a_ge_b ? sa : sb) & (mag_diff != '0), mag_diff};
        end
      end
      default: alu = '0;  // multiply goes through CALC
    endcase
    if (alu.err) alu.res = '0;
  end

  // ---------------------------------------------------------------
  // Iterative shift-add multiplier: one magnitude bit of B per cycle
  // ---------------------------------------------------------------
  logic [2*M-1:0] mul_a;     // multiplicand, shifted left each step
  logic [M-1:0]   mul_b;     // multiplier bits, shifted right each step
  logic [2*M-1:0] mul_acc;
  logic           mul_sign;
  logic [CW-1:0]  mul_cnt;
  logic [2*M-1:0] mul_prod;
  logic           mul_last;
  alu_out_t       mul;

  assign mul_prod = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_last = (mul_cnt == CW'(M - 1));

  always_comb begin
    mul     = '0;
    mul.err = |mul_prod[2*M-1:M];
    if (!mul.err) mul.res = {mul_sign & (mul_prod[M-1:0] != '0), mul_prod[M-1:0]};
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = (i_oper == OP_MUL) ? CALC : DONE;
      CALC:    if (mul_last) state_nxt = DONE;
      DONE:    if (i_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // o_ready is registered so it stays low for the reset cycle itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready  <= 1'b0;
      o_result <= '0;
      o_status <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_sign <= 1'b0;
      mul_cnt  <= '0;
    end else begin
      o_ready <= (state_nxt == IDLE);
      if (accept) begin
        mul_a    <= {{M{1'b0}}, ma};
        mul_b    <= mb;
        mul_sign <= sa ^ sb;
        mul_acc  <= '0;
        mul_cnt  <= '0;
        if (i_oper != OP_MUL) begin
          o_result <= alu.res;
          o_status <= status_of(alu);
        end
      end else if (state == CALC) begin
        mul_acc <= mul_prod;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        mul_cnt <= mul_cnt + 1'b1;
        if (mul_last) begin
          o_result <= mul.res;
          o_status <= status_of(mul);
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------
`ifdef EXE_UNIT_STATS_EN
  logic out_hs;
  assign out_hs = (state == DONE) & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_op_cnt  <= '0;
      o_err_cnt <= '0;
    end else if (out_hs) begin
      o_op_cnt <= o_op_cnt + 1'b1;
      if (o_status[3]) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
`else
  assign o_op_cnt  = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_unit_pipe.sv
// Bench for exe_unit_pipe at MBIT=4: scoreboard of expected {status,result}
// filled when a request is driven and drained on each output handshake.
module tb_exe_unit_pipe;

  localparam int MBIT = 4;
  localparam int NBIT = 3;
  localparam int CNTW = 16;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            o_ready;
  logic [MBIT-1:0] i_argA;
  logic [MBIT-1:0] i_argB;
  logic [NBIT-1:0] i_oper;
  logic            o_valid;
  logic            i_ready;
  logic [MBIT-1:0] o_result;
  logic [3:0]      o_status;
  logic [CNTW-1:0] o_op_cnt;
  logic [CNTW-1:0] o_err_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];   // {status, result}

  always #5 i_clk = ~i_clk;

  exe_unit_pipe #(.MBIT(MBIT), .NBIT(NBIT), .CNTW(CNTW)) u_dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_argA    (i_argA),
    .i_argB    (i_argB),
    .i_oper    (i_oper),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_status  (o_status),
    .o_op_cnt  (o_op_cnt),
    .o_err_cnt (o_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Encode a signed integer as 4-bit sign-magnitude, zero always +0.
  function automatic int zenc(input int v);
    return (v < 0) ? (8 | -v) : v;
  endfunction

  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int va, vb, v, r;
    bit err;
    logic [3:0] rr;
    va  = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
    vb  = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
    r   = 0;
    err = 1'b0;
    case (op)
      3'd0: r = {~b[3], b[2:0]};
      3'd1: r = (va >= vb) ? int'(a) : int'(b);
      3'd2, 3'd4: begin
        if (b[3] || b >= 4'd4) err = 1'b1;
        else if (op == 3'd2)   r = int'(a) & ~(1 << b);
        else                   r = int'(a) | (1 << b);
      end
      3'd3: begin
        if (a == 4'b1000) err = 1'b1;
        else              r = va & 15;
      end
      3'd5: begin
        if (a == 4'b1000) err = 1'b1;
        else begin
          v = a[3] ? int'(a) - 16 : int'(a);
          r = zenc(v);
        end
      end
      3'd6: begin
        v = va + vb;
        if (v > 7 || v < -7) err = 1'b1;
        else                 r = zenc(v);
      end
      default: begin
        v = va * vb;
        if (v > 7 || v < -7) err = 1'b1;
        else                 r = zenc(v);
      end
    endcase
    rr = err ? 4'd0 : r[3:0];
    return {err, ^rr, (rr == 4'd0), rr[3], rr};
  endfunction

  // Scoreboard drain: each output handshake pops one expectation.
  always @(negedge i_clk) begin
    logic [7:0] e;
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      chk("out_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", o_result, e[3:0]);
        chk("status", o_status, e[7:4]);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (o_ready !== 1'b1 && w < 30) begin
      tick();
      w++;
    end
    chk("ready_wait", o_ready, 1);
  endtask

  // Issue one request with i_ready=1 and check the accept-to-valid latency.
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int cyc;
    wait_ready();
    i_valid = 1'b1;
    i_oper  = op;
    i_argA  = a;
    i_argB  = b;
    exp_q.push_back(model(op, a, b));
    cyc = 0;
    do begin
      tick();
      i_valid = 1'b0;
      cyc++;
    end while (o_valid !== 1'b1 && cyc < 20);
    chk("latency", cyc, (op == 3'b111) ? MBIT : 1);
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  vec_t dir_tbl[21] = '{
    '{3'b110, 4'b0011, 4'b1101},  // +3 + -5 = -2
    '{3'b111, 4'b0011, 4'b0010},  // 3*2 = 6
    '{3'b111, 4'b0011, 4'b1011},  // 3*-3 overflow
    '{3'b011, 4'b1000, 4'b0000},  // -0 to U2: error
    '{3'b010, 4'b1111, 4'b0100},  // idx 4 out of range
    '{3'b010, 4'b1111, 4'b0001},  // clear bit 1
    '{3'b101, 4'b1110, 4'b0000},  // U2 -2 to Z
    '{3'b000, 4'b0101, 4'b0000},  // invert sign of +0
    '{3'b000, 4'b0000, 4'b1101},  // invert sign of -5
    '{3'b001, 4'b1000, 4'b0000},  // max(-0,+0): tie, A
    '{3'b001, 4'b1010, 4'b0011},  // max(-2,+3)
    '{3'b100, 4'b0000, 4'b0011},  // set bit 3
    '{3'b100, 4'b0000, 4'b1001},  // negative index
    '{3'b110, 4'b1001, 4'b1010},  // -1 + -2
    '{3'b110, 4'b0101, 4'b0110},  // 5+6 overflow
    '{3'b110, 4'b1011, 4'b0011},  // -3+3 = +0
    '{3'b111, 4'b1000, 4'b0101},  // -0*5 = +0
    '{3'b111, 4'b1111, 4'b1111},  // -7*-7 overflow
    '{3'b011, 4'b1101, 4'b0000},  // Z -5 to U2
    '{3'b101, 4'b1000, 4'b0000},  // U2 min: error
    '{3'b101, 4'b0111, 4'b0000}   // U2 +7 to Z
  };

  initial begin
    logic [7:0] e_hold;
    logic [7:0] e_next;
    int w;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_oper  = '0;
    i_argA  = '0;
    i_argB  = '0;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_result", o_result, 0);
    chk("rst_status", o_status, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready_low", o_ready, 0);
    tick();
    chk("rst_ready_high", o_ready, 1);
`ifdef EXE_UNIT_STATS_EN
    chk("rst_op_cnt", o_op_cnt, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
`endif

    foreach (dir_tbl[i]) run_op(dir_tbl[i].op, dir_tbl[i].a, dir_tbl[i].b);
    for (int i = 0; i < 24; i++)
      run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Backpressure: hold i_ready low in DONE while a second request waits.
    wait_ready();
    tick();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_oper  = 3'b110;
    i_argA  = 4'b0001;
    i_argB  = 4'b0010;
    e_hold  = model(3'b110, 4'b0001, 4'b0010);
    exp_q.push_back(e_hold);
    tick();
    i_oper = 3'b000;
    i_argA = 4'b0011;
    i_argB = 4'b0110;
    e_next = model(3'b000, 4'b0011, 4'b0110);
    exp_q.push_back(e_next);
    chk("hold_valid_first", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", o_valid, 1);
      chk("hold_result", o_result, e_hold[3:0]);
      chk("hold_status", o_status, e_hold[7:4]);
      chk("hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    tick();
    chk("post_hs_valid", o_valid, 0);
    chk("post_hs_ready", o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("second_valid", o_valid, 1);
    chk("second_result", o_result, e_next[3:0]);
    tick();

    // Reset during the second CALC cycle of a multiply: no result emitted.
    wait_ready();
    i_valid = 1'b1;
    i_oper  = 3'b111;
    i_argA  = 4'b0011;
    i_argB  = 4'b0010;
    tick();
    i_valid = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_valid", o_valid, 0);
    chk("abort_result", o_result, 0);
    chk("abort_status", o_status, 0);
    chk("abort_ready", o_ready, 0);
`ifdef EXE_UNIT_STATS_EN
    chk("abort_op_cnt", o_op_cnt, 0);
    chk("abort_err_cnt", o_err_cnt, 0);
`endif
    w = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_valid === 1'b1) w++;
    end
    chk("abort_no_output", w, 0);
    chk("abort_ready_back", o_ready, 1);

    run_op(3'b110, 4'b0001, 4'b0001);
    run_op(3'b111, 4'b0111, 4'b0111);
    run_op(3'b000, 4'b0011, 4'b0011);
    tick();
`ifdef EXE_UNIT_STATS_EN
    chk("op_cnt", o_op_cnt, 3);
    chk("err_cnt", o_err_cnt, 1);
`endif

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
